// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: shared types and constants for the memory-mapped UART transmitter.
//   - mem_write_control_t : store request as presented by the data memory
//   - UART_*_OFFSET       : register offsets from the block base address (word spaced)
//   - UART_STATUS_*       : bit positions inside the STATUS word
//   - uart_tx_state_t     : serialiser FSM states
package mmio_uart_tx_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MEM_WIDTH_BYTE,
        MEM_WIDTH_HALF,
        MEM_WIDTH_WORD
    } mem_width_t;

    typedef struct packed {
        logic            enable;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] value;
        mem_width_t      width;
    } mem_write_control_t;

    localparam logic [XLEN-1:0] UART_TXDATA_OFFSET  = 32'h0;
    localparam logic [XLEN-1:0] UART_STATUS_OFFSET  = 32'h4;
    localparam logic [XLEN-1:0] UART_DIVISOR_OFFSET = 32'h8;

    localparam int unsigned UART_STATUS_BUSY_BIT  = 0;
    localparam int unsigned UART_STATUS_FULL_BIT  = 1;
    localparam int unsigned UART_STATUS_EMPTY_BIT = 2;
    localparam int unsigned UART_STATUS_COUNT_LSB = 7;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_tx_state_t;

    // A divisor of zero would give a zero-length bit; clamp it to one cycle.
    function automatic logic [15:0] uart_bit_period(input logic [15:0] divisor);
        return (divisor == 16'd0) ? 16'd1 : divisor;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: MMIO write channel between the hart (master) and the UART (slave).
//   memory_mapped_io_control        : store request (enable/addr/value/width), master -> slave
//   memory_mapped_io_write_complete : request accepted, slave -> master
//   memory_mapped_io_r_data         : registered status word, slave -> master
interface mmio_uart_tx_if;
    import mmio_uart_tx_pkg::*;

    mem_write_control_t memory_mapped_io_control;
    logic               memory_mapped_io_write_complete;
    logic [XLEN-1:0]    memory_mapped_io_r_data;

    modport master (
        output memory_mapped_io_control,
        input  memory_mapped_io_write_complete,
        input  memory_mapped_io_r_data
    );

    modport slave (
        input  memory_mapped_io_control,
        output memory_mapped_io_write_complete,
        output memory_mapped_io_r_data
    );

endinterface

// File: rtl/mmio_uart_tx_byte_fifo.sv
// byte_fifo: synchronous byte FIFO, synchronous active-high reset.
//   clk_i, rst_i : clock and reset
//   push_i/data_i: write a byte; honoured when not full, or when full with a same-cycle pop
//   pop_i/data_o : data_o shows the head entry; pop_i removes it when non-empty
//   full_o, empty_o, count_o : occupancy (count is one bit wider than the pointers)
module byte_fifo #(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [7:0]      data_i,
    input  logic            pop_i,
    output logic [7:0]      data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees its slot in the same cycle, so a push into a full FIFO is taken
    // whenever the head is leaving.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Depth is a power of 2, so pointer overflow is the modulo wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the hart's MMIO write channel.
//   clock, reset : sole clock; synchronous active-high reset
//   mmio (slave) : store requests in; write_complete and status word out
//   uart_tx      : serial line, idles high
// Registers (offset from base_addr): 0x0 TXDATA (write pushes value[7:0]),
// 0x4 STATUS (read via r_data, writes ignored), 0x8 DIVISOR (value[15:0]).
// Completion is withheld while a TXDATA write meets a full FIFO, stalling the hart.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [XLEN-1:0] base_addr     = 32'h0003_0000,
    parameter int unsigned     fifo_depth    = 4,
    parameter int unsigned     reset_divisor = 16
) (
    input  logic           clock,
    input  logic           reset,
    mmio_uart_tx_if.slave  mmio,
    output logic           uart_tx
);

    localparam int unsigned CntW = $clog2(fifo_depth) + 1;
    localparam logic [XLEN-1:0] StatusReset = XLEN'(1) << UART_STATUS_EMPTY_BIT;

    mem_write_control_t ctl;
    logic               sel_txdata, sel_status, sel_divisor;
    logic               accept;
    logic               accepted_q, accepted_d;
    logic [15:0]        divisor_q, divisor_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]         fifo_rdata;
    logic [CntW-1:0]    fifo_count;

    uart_tx_state_t     state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [15:0]        bit_period_q, bit_period_d;
    logic               bit_done;

    logic [XLEN-1:0]    r_data_q, r_data_d;

    assign ctl         = mmio.memory_mapped_io_control;
    assign sel_txdata  = (ctl.addr == base_addr + UART_TXDATA_OFFSET);
    assign sel_status  = (ctl.addr == base_addr + UART_STATUS_OFFSET);
    assign sel_divisor = (ctl.addr == base_addr + UART_DIVISOR_OFFSET);

    // STATUS writes are accepted with no effect, same as unmapped addresses; width is
    // irrelevant since every register takes a fixed slice of value.
    logic unused_ctl;
    assign unused_ctl = ^{ctl.width, ctl.value[31:16], sel_status};

    // ---------------------------------------------------------------------------------
    // Request handshake: one side effect per request, held until enable drops.
    // ---------------------------------------------------------------------------------
    always_comb begin
        accept    = 1'b0;
        fifo_push = 1'b0;
        divisor_d = divisor_q;
        if (ctl.enable && !accepted_q) begin
            if (sel_txdata) begin
                if (!fifo_full || fifo_pop) begin
                    accept    = 1'b1;
                    fifo_push = 1'b1;
                end
            end else begin
                accept = 1'b1;
                if (sel_divisor) divisor_d = ctl.value[15:0];
            end
        end
        accepted_d = ctl.enable && (accepted_q || accept);
    end

    assign mmio.memory_mapped_io_write_complete = ctl.enable && accepted_q;

    byte_fifo #(
        .Depth (fifo_depth)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .data_i  (ctl.value[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------------------------------------------------------------------------
    // Serialiser FSM. bit_period is captured at the pop so a DIVISOR write mid-frame
    // only takes effect on the following frame.
    // ---------------------------------------------------------------------------------
    assign bit_done = (cnt_q == 16'd0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        bit_period_d = bit_period_q;
        fifo_pop     = 1'b0;
        case (state_q)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_d      = fifo_rdata;
                    bit_period_d = uart_bit_period(divisor_q);
                    cnt_d        = bit_period_d - 16'd1;
                    state_d      = UART_START;
                end
            end
            UART_START: begin
                if (bit_done) begin
                    cnt_d     = bit_period_q - 16'd1;
                    bit_idx_d = 3'd0;
                    state_d   = UART_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            UART_DATA: begin
                if (bit_done) begin
                    cnt_d     = bit_period_q - 16'd1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = UART_STOP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    state_d = UART_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            UART_START: uart_tx = 1'b0;
            UART_DATA:  uart_tx = shift_q[bit_idx_q];
            default:    uart_tx = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------------------------
    // Status word, registered every cycle regardless of addr.
    // ---------------------------------------------------------------------------------
    always_comb begin
        r_data_d                                     = '0;
        r_data_d[UART_STATUS_BUSY_BIT]               = (state_q != UART_IDLE);
        r_data_d[UART_STATUS_FULL_BIT]               = fifo_full;
        r_data_d[UART_STATUS_EMPTY_BIT]              = fifo_empty;
        r_data_d[UART_STATUS_COUNT_LSB +: CntW]      = fifo_count;
    end

    assign mmio.memory_mapped_io_r_data = r_data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= UART_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            bit_period_q <= 16'd1;
            divisor_q    <= 16'(reset_divisor);
            accepted_q   <= 1'b0;
            r_data_q     <= StatusReset;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            bit_period_q <= bit_period_d;
            divisor_q    <= divisor_d;
            accepted_q   <= accepted_d;
            r_data_q     <= r_data_d;
        end
    end

endmodule
